// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory access
// and writeback, stalling on mem_ready in the memory-facing states.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   FETCH    (0) | read instruction at PC, load IR and PC+4 when mem_ready
//   DECODE   (1) | dispatch on opcode, precompute branch target
//   MEMADR   (2) | compute load/store address
//   MEMRD    (3) | data read at ALUOut, wait for mem_ready
//   MEMWB    (4) | write MDR to rt
//   MEMWR    (5) | data write at ALUOut, wait for mem_ready
//   EXEC     (6) | R-type ALU operation
//   ALUWB    (7) | write ALUOut to rd
//   BRANCH   (8) | compare operands, take branch when zero
//   ADDIEXEC (9) | reg A + sign-extended immediate
//   ADDIWB  (10) | write ALUOut to rt
//   JUMP    (11) | load PC with jump target
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t cur, nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt        = S_FETCH;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        // Reset silences every strobe, even FETCH's read of the PC.
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    nxt       = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_R:         nxt = S_EXEC;
                        OP_LW, OP_SW: nxt = S_MEMADR;
                        OP_BEQ:       nxt = S_BRANCH;
                        OP_ADDI:      nxt = S_ADDIEXEC;
                        OP_J:         nxt = S_JUMP;
                        default: begin
                            nxt        = S_FETCH;
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    // Anything but lw finishes through the store path so
                    // the instruction still retires with one instr_done.
                    nxt       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    nxt      = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                    nxt        = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    nxt       = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_src     = 2'b01;
                    pc_en      = zero;
                    instr_done = 1'b1;
                end
                S_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    nxt       = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle vector table, reset abort sequence,
// then random instructions checked against an instruction-level model.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [3:0] state;
    logic       mem_read, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       illegal, instr_done;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .state(state), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, instr_done};

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic [3:0]  st;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, ADDI = 6'h08, J = 6'h02;

    function automatic logic [16:0] mk(logic mr, logic mw, logic io, logic irw, logic pce,
                                       logic [1:0] pcs, logic rw, logic rd, logic m2r,
                                       logic asa, logic [1:0] asb, logic [1:0] aop,
                                       logic ill, logic done);
        return {mr, mw, io, irw, pce, pcs, rw, rd, m2r, asa, asb, aop, ill, done};
    endfunction

    task automatic add(input logic [5:0] op, input logic rdy, input logic z,
                       input logic [3:0] st, input logic [16:0] exp);
        vec_t v;
        v.op = op; v.rdy = rdy; v.z = z; v.st = st; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(logic [5:0] op);
        return op == R || op == LW || op == SW || op == BEQ || op == ADDI || op == J;
    endfunction

    logic [16:0] f_go, f_wait, dec, madr;

    initial begin
        f_go   = mk(1,0,0,1,1,2'd0,0,0,0,0,2'd1,2'd0,0,0);
        f_wait = mk(1,0,0,0,0,2'd0,0,0,0,0,2'd1,2'd0,0,0);
        dec    = mk(0,0,0,0,0,2'd0,0,0,0,0,2'd3,2'd0,0,0);
        madr   = mk(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,0,0);
        // R-type
        add(R, 1, 0, 4'd0, f_go);
        add(R, 1, 0, 4'd1, dec);
        add(R, 1, 0, 4'd6, mk(0,0,0,0,0,2'd0,0,0,0,1,2'd0,2'd2,0,0));
        add(R, 1, 0, 4'd7, mk(0,0,0,0,0,2'd0,1,1,0,0,2'd0,2'd0,0,1));
        // lw with two wait cycles in MEMRD
        add(LW, 1, 0, 4'd0, f_go);
        add(LW, 1, 0, 4'd1, dec);
        add(LW, 1, 0, 4'd2, madr);
        add(LW, 0, 0, 4'd3, mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0));
        add(LW, 0, 0, 4'd3, mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0));
        add(LW, 1, 0, 4'd3, mk(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0));
        add(LW, 1, 0, 4'd4, mk(0,0,0,0,0,2'd0,1,0,1,0,2'd0,2'd0,0,1));
        // beq taken
        add(BEQ, 1, 0, 4'd0, f_go);
        add(BEQ, 1, 0, 4'd1, dec);
        add(BEQ, 1, 1, 4'd8, mk(0,0,0,0,1,2'd1,0,0,0,1,2'd0,2'd1,0,1));
        // beq not taken, with a fetch wait
        add(BEQ, 0, 1, 4'd0, f_wait);
        add(BEQ, 1, 1, 4'd0, f_go);
        add(BEQ, 1, 1, 4'd1, dec);
        add(BEQ, 1, 0, 4'd8, mk(0,0,0,0,0,2'd1,0,0,0,1,2'd0,2'd1,0,1));
        // j
        add(J, 1, 0, 4'd0, f_go);
        add(J, 1, 0, 4'd1, dec);
        add(J, 1, 0, 4'd11, mk(0,0,0,0,1,2'd2,0,0,0,0,2'd0,2'd0,0,1));
        // sw with one wait cycle
        add(SW, 1, 0, 4'd0, f_go);
        add(SW, 1, 0, 4'd1, dec);
        add(SW, 1, 0, 4'd2, madr);
        add(SW, 0, 0, 4'd5, mk(0,1,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0));
        add(SW, 1, 0, 4'd5, mk(0,1,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,1));
        // addi
        add(ADDI, 1, 0, 4'd0, f_go);
        add(ADDI, 1, 0, 4'd1, dec);
        add(ADDI, 1, 0, 4'd9, madr);
        add(ADDI, 1, 0, 4'd10, mk(0,0,0,0,0,2'd0,1,0,0,0,2'd0,2'd0,0,1));
        // illegal opcode
        add(6'h3F, 1, 0, 4'd0, f_go);
        add(6'h3F, 1, 0, 4'd1, mk(0,0,0,0,0,2'd0,0,0,0,0,2'd3,2'd0,1,1));
        add(6'h3F, 0, 0, 4'd0, f_wait);
    end

    initial begin
        reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_outs", {15'd0, outs}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            opcode = tbl[i].op; mem_ready = tbl[i].rdy; zero = tbl[i].z;
            #1;
            chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, tbl[i].st});
            chk($sformatf("vec%0d_outs", i), {15'd0, outs}, {15'd0, tbl[i].exp});
            @(negedge clk);
        end

        // Reset asserted while a load waits in MEMRD
        opcode = LW; mem_ready = 1'b1; zero = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("abort_pre_state", {28'd0, state}, 32'd3);
        reset = 1'b1;
        #1;
        chk("abort_state", {28'd0, state}, 32'd0);
        chk("abort_outs", {15'd0, outs}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("abort_hold_outs", {15'd0, outs}, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        chk("release_state", {28'd0, state}, 32'd0);
        chk("release_mem_read", {31'd0, mem_read}, 32'd1);
        chk("release_iord", {31'd0, iord}, 32'd0);
        @(negedge clk);
        #1;
        chk("release_no_wb", {28'd0, state, 3'd0, reg_write}, 32'd0);
        @(negedge clk);

        // Random instructions against an instruction-level model
        for (int n = 0; n < 200; n++) begin
            int kind, wf, wm, total, base;
            bit zb, is_mem;
            logic [5:0] op;
            int c_mr, c_mw, c_irw, c_pce, c_rw, c_ill, c_done, done_at, excl, wb_dst, wb_m2r;
            kind = $urandom_range(0, 6);
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            zb = 1'($urandom_range(0, 1));
            case (kind)
                0: begin op = R;    base = 4; end
                1: begin op = LW;   base = 5; end
                2: begin op = SW;   base = 4; end
                3: begin op = BEQ;  base = 3; end
                4: begin op = ADDI; base = 4; end
                5: begin op = J;    base = 3; end
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                    base = 2;
                end
            endcase
            is_mem = (kind == 1) || (kind == 2);
            total = base + wf + (is_mem ? wm : 0);
            c_mr = 0; c_mw = 0; c_irw = 0; c_pce = 0; c_rw = 0; c_ill = 0;
            c_done = 0; done_at = -1; excl = 0; wb_dst = 0; wb_m2r = 0;
            #1;
            chk($sformatf("rnd%0d_start_state", n), {28'd0, state}, 32'd0);
            for (int c = 0; c < total; c++) begin
                opcode = op;
                if (c < wf) mem_ready = 1'b0;
                else if (c == wf) mem_ready = 1'b1;
                else if (is_mem && c >= wf + 3 && c < wf + 3 + wm) mem_ready = 1'b0;
                else if (is_mem && c == wf + 3 + wm) mem_ready = 1'b1;
                else mem_ready = 1'($urandom);
                zero = (kind == 3 && c == wf + 2) ? zb : 1'($urandom);
                #1;
                c_mr += int'(mem_read); c_mw += int'(mem_write); c_irw += int'(ir_write);
                c_pce += int'(pc_en); c_rw += int'(reg_write); c_ill += int'(illegal);
                if (instr_done) begin c_done++; done_at = c; end
                if ((mem_read && mem_write) || (reg_write && pc_en)) excl++;
                if (reg_write) begin wb_dst = int'(reg_dst); wb_m2r = int'(mem_to_reg); end
                @(negedge clk);
            end
            chk($sformatf("rnd%0d_op%0h_mem_read", n, op), c_mr, wf + 1 + ((kind == 1) ? wm + 1 : 0));
            chk($sformatf("rnd%0d_op%0h_mem_write", n, op), c_mw, (kind == 2) ? wm + 1 : 0);
            chk($sformatf("rnd%0d_op%0h_ir_write", n, op), c_irw, 1);
            chk($sformatf("rnd%0d_op%0h_pc_en", n, op), c_pce,
                1 + ((kind == 3 && zb) ? 1 : 0) + ((kind == 5) ? 1 : 0));
            chk($sformatf("rnd%0d_op%0h_reg_write", n, op), c_rw,
                (kind == 0 || kind == 1 || kind == 4) ? 1 : 0);
            chk($sformatf("rnd%0d_op%0h_illegal", n, op), c_ill, (kind == 6) ? 1 : 0);
            chk($sformatf("rnd%0d_op%0h_done_count", n, op), c_done, 1);
            chk($sformatf("rnd%0d_op%0h_done_cycle", n, op), done_at, total - 1);
            chk($sformatf("rnd%0d_op%0h_exclusive", n, op), excl, 0);
            if (kind == 0 || kind == 1 || kind == 4) begin
                chk($sformatf("rnd%0d_op%0h_wb_dst", n, op), wb_dst, (kind == 0) ? 1 : 0);
                chk($sformatf("rnd%0d_op%0h_wb_m2r", n, op), wb_m2r, (kind == 1) ? 1 : 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
